// File: rtl/down_min_sec.sv
// down_min_sec: MM:SS BCD countdown timer (00:00 to 99:59) with preset load,
// start/pause control, a one-cycle done pulse and a sticky expired flag.
// Optional feature: define COUNTDOWN_AUTORELOAD_EN to reload the stored preset
// on expiry and keep running instead of stopping at 00:00.

module down_min_sec (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start_stop,
    input  logic       load,
    input  logic [3:0] pre_min1,
    input  logic [3:0] pre_min0,
    input  logic [3:0] pre_sec1,
    input  logic [3:0] pre_sec0,
    output logic [3:0] min1,
    output logic [3:0] min0,
    output logic [3:0] sec1,
    output logic [3:0] sec0,
    output logic       running,
    output logic       expired,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} stateT;

    stateT      r_state;
    stateT      w_stateNext;
    logic [3:0] r_min1, r_min0, r_sec1, r_sec0;
    logic [3:0] w_min1Next, w_min0Next, w_sec1Next, w_sec0Next;
    logic [3:0] r_preMin1, r_preMin0, r_preSec1, r_preSec0;
    logic [3:0] w_preMin1Next, w_preMin0Next, w_preSec1Next, w_preSec0Next;
    logic       r_done;
    logic       w_doneNext;
    logic       w_isZero;
    logic       w_isOne;
    logic       w_canStart;

    // Clamp a BCD digit to an upper bound so out-of-range presets stay legal.
    function automatic logic [3:0] clampDigit(input logic [3:0] d, input logic [3:0] maxV);
        return (d > maxV) ? maxV : d;
    endfunction

    assign w_isZero = (r_min1 == 4'd0) && (r_min0 == 4'd0) && (r_sec1 == 4'd0) && (r_sec0 == 4'd0);
    assign w_isOne  = (r_min1 == 4'd0) && (r_min0 == 4'd0) && (r_sec1 == 4'd0) && (r_sec0 == 4'd1);

`ifdef COUNTDOWN_AUTORELOAD_EN
    // A zero preset would reload to zero forever, so it also blocks starting.
    assign w_canStart = !w_isZero &&
                        !((r_preMin1 == 4'd0) && (r_preMin0 == 4'd0) &&
                          (r_preSec1 == 4'd0) && (r_preSec0 == 4'd0));
`else
    assign w_canStart = !w_isZero;
`endif

    // Next-state logic: load beats start_stop, which beats tick.
    always_comb begin
        w_stateNext   = r_state;
        w_min1Next    = r_min1;
        w_min0Next    = r_min0;
        w_sec1Next    = r_sec1;
        w_sec0Next    = r_sec0;
        w_preMin1Next = r_preMin1;
        w_preMin0Next = r_preMin0;
        w_preSec1Next = r_preSec1;
        w_preSec0Next = r_preSec0;
        w_doneNext    = 1'b0;

        if (load) begin
            w_preMin1Next = clampDigit(pre_min1, 4'd9);
            w_preMin0Next = clampDigit(pre_min0, 4'd9);
            w_preSec1Next = clampDigit(pre_sec1, 4'd5);
            w_preSec0Next = clampDigit(pre_sec0, 4'd9);
            w_min1Next    = w_preMin1Next;
            w_min0Next    = w_preMin0Next;
            w_sec1Next    = w_preSec1Next;
            w_sec0Next    = w_preSec0Next;
            w_stateNext   = IDLE;
        end else if (start_stop) begin
            case (r_state)
                IDLE, PAUSE: if (w_canStart) w_stateNext = RUN;
                RUN:         w_stateNext = PAUSE;
                default:     w_stateNext = r_state;
            endcase
        end else if (tick && (r_state == RUN)) begin
            if (w_isOne) begin
                w_doneNext = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                w_min1Next = r_preMin1;
                w_min0Next = r_preMin0;
                w_sec1Next = r_preSec1;
                w_sec0Next = r_preSec0;
`else
                w_sec0Next  = 4'd0;
                w_stateNext = DONE;
`endif
            end else if (!w_isZero) begin
                if (r_sec0 != 4'd0) begin
                    w_sec0Next = r_sec0 - 4'd1;
                end else begin
                    w_sec0Next = 4'd9;
                    if (r_sec1 != 4'd0) begin
                        w_sec1Next = r_sec1 - 4'd1;
                    end else begin
                        w_sec1Next = 4'd5;
                        if (r_min0 != 4'd0) begin
                            w_min0Next = r_min0 - 4'd1;
                        end else begin
                            w_min0Next = 4'd9;
                            w_min1Next = r_min1 - 4'd1;
                        end
                    end
                end
            end
        end
    end

    // State, digit, preset and done-pulse registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_min1    <= 4'd0;
            r_min0    <= 4'd0;
            r_sec1    <= 4'd0;
            r_sec0    <= 4'd0;
            r_preMin1 <= 4'd0;
            r_preMin0 <= 4'd0;
            r_preSec1 <= 4'd0;
            r_preSec0 <= 4'd0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_min1    <= w_min1Next;
            r_min0    <= w_min0Next;
            r_sec1    <= w_sec1Next;
            r_sec0    <= w_sec0Next;
            r_preMin1 <= w_preMin1Next;
            r_preMin0 <= w_preMin0Next;
            r_preSec1 <= w_preSec1Next;
            r_preSec0 <= w_preSec0Next;
            r_done    <= w_doneNext;
        end
    end

    assign min1    = r_min1;
    assign min0    = r_min0;
    assign sec1    = r_sec1;
    assign sec0    = r_sec0;
    assign running = (r_state == RUN);
    assign expired = (r_state == DONE);
    assign done    = r_done;

endmodule
